// File: rtl/input_capture_channel.sv
// ============================================================================
// Module   : input_capture_channel
// Brief    : Timer input-capture stage. It detects qualified edges, applies an
//            event prescaler, latches the counter value and raises the
//            capture/overcapture flags.
//            Define IC_SW_TRIG_EN to add the swtrig_i software capture port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module input_capture_channel #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             af_i,
    input  logic [1:0]       pol_i,
    input  logic [1:0]       psc_i,
    input  logic [CNT_W-1:0] cnt_i,
    input  logic             ccr_rd_i,
    input  logic             ccif_clr_i,
    input  logic             ccof_clr_i,
`ifdef IC_SW_TRIG_EN
    input  logic             swtrig_i,
`endif
    output logic [CNT_W-1:0] ccr_o,
    output logic             ccif_o,
    output logic             ccof_o,
    output logic             cap_evt_o
);

    localparam logic [1:0] c_POL_FALL = 2'b01;
    localparam logic [1:0] c_POL_BOTH = 2'b11;

    logic             r_af_d;
    logic [2:0]       r_psc_cnt;
    logic [CNT_W-1:0] r_ccr;
    logic             r_ccif;
    logic             r_ccof;
    logic             r_cap_evt;

    logic       w_rise;
    logic       w_fall;
    logic       w_edge;
    logic       w_qual;
    logic [2:0] w_target;
    logic       w_hw_cap;
    logic       w_sw_cap;
    logic       w_cap;

    assign w_rise = af_i & ~r_af_d;
    assign w_fall = ~af_i & r_af_d;

    // Polarity code 10 is treated as rising edge, same as 00.
    always_comb begin
        w_edge = w_rise;
        case (pol_i)
            c_POL_FALL: w_edge = w_fall;
            c_POL_BOTH: w_edge = w_rise | w_fall;
            default:    w_edge = w_rise;
        endcase
    end

    assign w_qual = en_i & w_edge;

    always_comb begin
        w_target = 3'd0;
        case (psc_i)
            2'b00:   w_target = 3'd0;
            2'b01:   w_target = 3'd1;
            2'b10:   w_target = 3'd3;
            default: w_target = 3'd7;
        endcase
    end

    // Greater-or-equal so that lowering psc_i mid-count fires on the next edge.
    assign w_hw_cap = w_qual & (r_psc_cnt >= w_target);

`ifdef IC_SW_TRIG_EN
    assign w_sw_cap = swtrig_i;
`else
    assign w_sw_cap = 1'b0;
`endif

    assign w_cap = w_hw_cap | w_sw_cap;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_af_d    <= 1'b0;
            r_psc_cnt <= 3'd0;
            r_ccr     <= '0;
            r_ccif    <= 1'b0;
            r_ccof    <= 1'b0;
            r_cap_evt <= 1'b0;
        end else begin
            r_af_d    <= af_i;
            r_cap_evt <= w_cap;

            // A software trigger never touches the prescale count.
            if (!en_i) begin
                r_psc_cnt <= 3'd0;
            end else if (w_qual) begin
                r_psc_cnt <= w_hw_cap ? 3'd0 : r_psc_cnt + 3'd1;
            end

            if (w_cap) begin
                r_ccr <= cnt_i;
            end

            if (w_cap) begin
                r_ccif <= 1'b1;
            end else if (ccr_rd_i || ccif_clr_i) begin
                r_ccif <= 1'b0;
            end

            // A read in the same cycle as a capture consumes the old value.
            if (w_cap && r_ccif && !ccr_rd_i) begin
                r_ccof <= 1'b1;
            end else if (ccof_clr_i) begin
                r_ccof <= 1'b0;
            end
        end
    end

    assign ccr_o     = r_ccr;
    assign ccif_o    = r_ccif;
    assign ccof_o    = r_ccof;
    assign cap_evt_o = r_cap_evt;

endmodule

`default_nettype wire

// File: tb/tb_input_capture_channel.sv
// ============================================================================
// Module   : tb_input_capture_channel
// Brief    : Directed vector bench for input_capture_channel. It contains
//            software-trigger vectors when IC_SW_TRIG_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_input_capture_channel;

    typedef struct {
        logic        rst;
        logic        en;
        logic        af;
        logic [1:0]  pol;
        logic [1:0]  psc;
        logic [15:0] cnt;
        logic        rd;
        logic        ic;
        logic        oc;
        logic        sw;
        logic [15:0] eccr;
        logic        eif;
        logic        eof;
        logic        eevt;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        af;
    logic [1:0]  pol;
    logic [1:0]  psc;
    logic [15:0] cnt;
    logic        rd;
    logic        ic;
    logic        oc;
`ifdef IC_SW_TRIG_EN
    logic        swtrig;
`endif
    logic [15:0] ccr;
    logic        ccif;
    logic        ccof;
    logic        evt;

    int n_vec = 0;
    int n_err = 0;
    vec_t tbl[$];

    always #5 clk = ~clk;

    input_capture_channel #(.CNT_W(16)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .en_i       (en),
        .af_i       (af),
        .pol_i      (pol),
        .psc_i      (psc),
        .cnt_i      (cnt),
        .ccr_rd_i   (rd),
        .ccif_clr_i (ic),
        .ccof_clr_i (oc),
`ifdef IC_SW_TRIG_EN
        .swtrig_i   (swtrig),
`endif
        .ccr_o      (ccr),
        .ccif_o     (ccif),
        .ccof_o     (ccof),
        .cap_evt_o  (evt)
    );

    function automatic vec_t mk(
        input logic rst_v, input logic en_v, input logic af_v,
        input logic [1:0] pol_v, input logic [1:0] psc_v, input logic [15:0] cnt_v,
        input logic rd_v, input logic ic_v, input logic oc_v,
        input logic [15:0] eccr_v, input logic eif_v, input logic eof_v, input logic eevt_v,
        input logic sw_v = 1'b0);
        vec_t v;
        v.rst = rst_v; v.en = en_v; v.af = af_v; v.pol = pol_v; v.psc = psc_v;
        v.cnt = cnt_v; v.rd = rd_v; v.ic = ic_v; v.oc = oc_v; v.sw = sw_v;
        v.eccr = eccr_v; v.eif = eif_v; v.eof = eof_v; v.eevt = eevt_v;
        return v;
    endfunction

    // Drive on the falling edge, then check #1 after the following rising edge.
    task automatic apply(input vec_t v, input string name);
        @(negedge clk);
        rst = v.rst; en = v.en; af = v.af; pol = v.pol; psc = v.psc;
        cnt = v.cnt; rd = v.rd; ic = v.ic; oc = v.oc;
`ifdef IC_SW_TRIG_EN
        swtrig = v.sw;
`endif
        @(posedge clk);
        #1;
        n_vec++;
        if (ccr !== v.eccr || ccif !== v.eif || ccof !== v.eof || evt !== v.eevt) begin
            n_err++;
            $display("FAIL %s: got ccr=%h ccif=%b ccof=%b evt=%b, expected ccr=%h ccif=%b ccof=%b evt=%b",
                     name, ccr, ccif, ccof, evt, v.eccr, v.eif, v.eof, v.eevt);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; en = 1'b0; af = 1'b0; pol = 2'b00; psc = 2'b00;
        cnt = 16'h0; rd = 1'b0; ic = 1'b0; oc = 1'b0;
`ifdef IC_SW_TRIG_EN
        swtrig = 1'b0;
`endif

        //                  rst  en   af   pol    psc    cnt       rd   ic   oc   eccr      eif  eof  evt
        // reset
        tbl.push_back(mk(1'b1,1'b0,1'b0,2'b00,2'b00,16'h0000,1'b0,1'b0,1'b0,16'h0000,1'b0,1'b0,1'b0));
        // basic rising capture
        tbl.push_back(mk(1'b0,1'b1,1'b0,2'b00,2'b00,16'h1000,1'b0,1'b0,1'b0,16'h0000,1'b0,1'b0,1'b0));
        tbl.push_back(mk(1'b0,1'b1,1'b1,2'b00,2'b00,16'h1234,1'b0,1'b0,1'b0,16'h1234,1'b1,1'b0,1'b1));
        tbl.push_back(mk(1'b0,1'b1,1'b1,2'b00,2'b00,16'h1235,1'b0,1'b1,1'b0,16'h1234,1'b0,1'b0,1'b0));
        // falling polarity: rises ignored, fall captures
        tbl.push_back(mk(1'b0,1'b1,1'b0,2'b00,2'b00,16'h2000,1'b0,1'b0,1'b0,16'h1234,1'b0,1'b0,1'b0));
        tbl.push_back(mk(1'b0,1'b1,1'b1,2'b01,2'b00,16'h2001,1'b0,1'b0,1'b0,16'h1234,1'b0,1'b0,1'b0));
        tbl.push_back(mk(1'b0,1'b0,1'b0,2'b01,2'b00,16'h2002,1'b0,1'b0,1'b0,16'h1234,1'b0,1'b0,1'b0));
        tbl.push_back(mk(1'b0,1'b1,1'b1,2'b01,2'b00,16'h2003,1'b0,1'b0,1'b0,16'h1234,1'b0,1'b0,1'b0));
        tbl.push_back(mk(1'b0,1'b0,1'b0,2'b01,2'b00,16'h2004,1'b0,1'b0,1'b0,16'h1234,1'b0,1'b0,1'b0));
        tbl.push_back(mk(1'b0,1'b1,1'b1,2'b01,2'b00,16'h2005,1'b0,1'b0,1'b0,16'h1234,1'b0,1'b0,1'b0));
        tbl.push_back(mk(1'b0,1'b1,1'b0,2'b01,2'b00,16'h00FF,1'b0,1'b0,1'b0,16'h00FF,1'b1,1'b0,1'b1));
        // overcapture, ccof clear, capture with read, read clears ccif
        tbl.push_back(mk(1'b0,1'b1,1'b1,2'b00,2'b00,16'h0300,1'b0,1'b0,1'b0,16'h0300,1'b1,1'b1,1'b1));
        tbl.push_back(mk(1'b0,1'b1,1'b0,2'b00,2'b00,16'h0301,1'b0,1'b0,1'b1,16'h0300,1'b1,1'b0,1'b0));
        tbl.push_back(mk(1'b0,1'b1,1'b1,2'b00,2'b00,16'h0400,1'b1,1'b0,1'b0,16'h0400,1'b1,1'b0,1'b1));
        tbl.push_back(mk(1'b0,1'b1,1'b0,2'b00,2'b00,16'h0401,1'b1,1'b0,1'b0,16'h0400,1'b0,1'b0,1'b0));
        // set wins over clear for both flags
        tbl.push_back(mk(1'b0,1'b1,1'b1,2'b00,2'b00,16'h0500,1'b0,1'b1,1'b0,16'h0500,1'b1,1'b0,1'b1));
        tbl.push_back(mk(1'b0,1'b1,1'b0,2'b00,2'b00,16'h0501,1'b0,1'b0,1'b0,16'h0500,1'b1,1'b0,1'b0));
        tbl.push_back(mk(1'b0,1'b1,1'b1,2'b00,2'b00,16'h0600,1'b0,1'b0,1'b1,16'h0600,1'b1,1'b1,1'b1));
        tbl.push_back(mk(1'b0,1'b1,1'b0,2'b00,2'b00,16'h0601,1'b0,1'b1,1'b1,16'h0600,1'b0,1'b0,1'b0));
        // enable while af high: no false edge
        tbl.push_back(mk(1'b0,1'b0,1'b1,2'b00,2'b00,16'h0700,1'b0,1'b0,1'b0,16'h0600,1'b0,1'b0,1'b0));
        tbl.push_back(mk(1'b0,1'b1,1'b1,2'b00,2'b00,16'h0701,1'b0,1'b0,1'b0,16'h0600,1'b0,1'b0,1'b0));
        // psc=/4: two edges, reset, then four fresh edges needed
        tbl.push_back(mk(1'b0,1'b1,1'b0,2'b00,2'b10,16'h0800,1'b0,1'b0,1'b0,16'h0600,1'b0,1'b0,1'b0));
        tbl.push_back(mk(1'b0,1'b1,1'b1,2'b00,2'b10,16'h0801,1'b0,1'b0,1'b0,16'h0600,1'b0,1'b0,1'b0));
        tbl.push_back(mk(1'b0,1'b1,1'b0,2'b00,2'b10,16'h0802,1'b0,1'b0,1'b0,16'h0600,1'b0,1'b0,1'b0));
        tbl.push_back(mk(1'b0,1'b1,1'b1,2'b00,2'b10,16'h0803,1'b0,1'b0,1'b0,16'h0600,1'b0,1'b0,1'b0));
        tbl.push_back(mk(1'b0,1'b1,1'b0,2'b00,2'b10,16'h0804,1'b0,1'b0,1'b0,16'h0600,1'b0,1'b0,1'b0));
        tbl.push_back(mk(1'b1,1'b1,1'b0,2'b00,2'b10,16'h0805,1'b0,1'b0,1'b0,16'h0000,1'b0,1'b0,1'b0));
        tbl.push_back(mk(1'b0,1'b1,1'b1,2'b00,2'b10,16'h0806,1'b0,1'b0,1'b0,16'h0000,1'b0,1'b0,1'b0));
        tbl.push_back(mk(1'b0,1'b1,1'b0,2'b00,2'b10,16'h0807,1'b0,1'b0,1'b0,16'h0000,1'b0,1'b0,1'b0));
        tbl.push_back(mk(1'b0,1'b1,1'b1,2'b00,2'b10,16'h0808,1'b0,1'b0,1'b0,16'h0000,1'b0,1'b0,1'b0));
        tbl.push_back(mk(1'b0,1'b1,1'b0,2'b00,2'b10,16'h0809,1'b0,1'b0,1'b0,16'h0000,1'b0,1'b0,1'b0));
        tbl.push_back(mk(1'b0,1'b1,1'b1,2'b00,2'b10,16'h080A,1'b0,1'b0,1'b0,16'h0000,1'b0,1'b0,1'b0));
        tbl.push_back(mk(1'b0,1'b1,1'b0,2'b00,2'b10,16'h080B,1'b0,1'b0,1'b0,16'h0000,1'b0,1'b0,1'b0));
        tbl.push_back(mk(1'b0,1'b1,1'b1,2'b00,2'b10,16'h0900,1'b0,1'b0,1'b0,16'h0900,1'b1,1'b0,1'b1));
        tbl.push_back(mk(1'b0,1'b1,1'b0,2'b00,2'b10,16'h0901,1'b0,1'b0,1'b0,16'h0900,1'b1,1'b0,1'b0));
        // psc lowered mid-count fires on next edge
        tbl.push_back(mk(1'b0,1'b1,1'b1,2'b11,2'b11,16'h0902,1'b0,1'b1,1'b0,16'h0900,1'b0,1'b0,1'b0));
        tbl.push_back(mk(1'b0,1'b1,1'b0,2'b11,2'b11,16'h0903,1'b0,1'b0,1'b0,16'h0900,1'b0,1'b0,1'b0));
        tbl.push_back(mk(1'b0,1'b1,1'b1,2'b11,2'b11,16'h0904,1'b0,1'b0,1'b0,16'h0900,1'b0,1'b0,1'b0));
        tbl.push_back(mk(1'b0,1'b1,1'b0,2'b11,2'b01,16'h0A00,1'b0,1'b0,1'b0,16'h0A00,1'b1,1'b0,1'b1));
        // boundary counter values, raw storage
        tbl.push_back(mk(1'b0,1'b1,1'b1,2'b11,2'b00,16'hFFFF,1'b1,1'b0,1'b0,16'hFFFF,1'b1,1'b0,1'b1));
        tbl.push_back(mk(1'b0,1'b1,1'b0,2'b11,2'b00,16'h0000,1'b0,1'b0,1'b0,16'h0000,1'b1,1'b1,1'b1));
        tbl.push_back(mk(1'b0,1'b0,1'b1,2'b11,2'b00,16'h0001,1'b0,1'b0,1'b0,16'h0000,1'b1,1'b1,1'b0));

        foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

        // Both edges with psc=/4: eight edges, captures only on edges 4 and 8.
        apply(mk(1'b0,1'b1,1'b1,2'b11,2'b10,16'h1000,1'b0,1'b1,1'b1,16'h0000,1'b0,1'b0,1'b0), "both_setup");
        for (int k = 0; k < 8; k++) begin
            logic [15:0] e_ccr;
            logic [15:0] k_cnt;
            k_cnt = 16'h1100 + 16'(k);
            e_ccr = (k >= 7) ? 16'h1107 : (k >= 3) ? 16'h1103 : 16'h0000;
            apply(mk(1'b0, 1'b1, (k % 2) == 1, 2'b11, 2'b10, k_cnt, 1'b0, 1'b0, 1'b0,
                     e_ccr, k >= 3, k >= 7, (k == 3) || (k == 7)),
                  $sformatf("both_edge%0d", k + 1));
        end

`ifdef IC_SW_TRIG_EN
        // Software trigger: bypasses the prescaler without disturbing its count.
        apply(mk(1'b0,1'b1,1'b0,2'b00,2'b10,16'h2000,1'b0,1'b1,1'b1,16'h1107,1'b0,1'b0,1'b0), "sw0");
        apply(mk(1'b0,1'b1,1'b1,2'b00,2'b10,16'h2001,1'b0,1'b0,1'b0,16'h1107,1'b0,1'b0,1'b0), "sw1");
        apply(mk(1'b0,1'b1,1'b1,2'b00,2'b10,16'hBEEF,1'b0,1'b0,1'b0,16'hBEEF,1'b1,1'b0,1'b1,1'b1), "sw_trig");
        apply(mk(1'b0,1'b1,1'b0,2'b00,2'b10,16'h2003,1'b0,1'b0,1'b0,16'hBEEF,1'b1,1'b0,1'b0), "sw3");
        apply(mk(1'b0,1'b1,1'b1,2'b00,2'b10,16'h2004,1'b0,1'b0,1'b0,16'hBEEF,1'b1,1'b0,1'b0), "sw4");
        apply(mk(1'b0,1'b1,1'b0,2'b00,2'b10,16'h2005,1'b0,1'b0,1'b0,16'hBEEF,1'b1,1'b0,1'b0), "sw5");
        apply(mk(1'b0,1'b1,1'b1,2'b00,2'b10,16'h2006,1'b0,1'b0,1'b0,16'hBEEF,1'b1,1'b0,1'b0), "sw6");
        apply(mk(1'b0,1'b1,1'b0,2'b00,2'b10,16'h2007,1'b0,1'b0,1'b0,16'hBEEF,1'b1,1'b0,1'b0), "sw7");
        apply(mk(1'b0,1'b1,1'b1,2'b00,2'b10,16'h2222,1'b0,1'b0,1'b0,16'h2222,1'b1,1'b1,1'b1), "sw_psc_kept");
        apply(mk(1'b0,1'b0,1'b0,2'b00,2'b10,16'hBEEF,1'b1,1'b0,1'b0,16'hBEEF,1'b1,1'b1,1'b1,1'b1), "sw_en0");
        apply(mk(1'b0,1'b0,1'b0,2'b00,2'b10,16'h3000,1'b0,1'b0,1'b0,16'hBEEF,1'b1,1'b1,1'b0), "sw_idle");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
